// File: rtl/uram_row_arbiter.sv
// Round-robin arbiter that hands one shared URAM port to one core of a row at a time.
// Optional watchdog revocation is built when the URAM_ARB_TIMEOUT_EN macro is defined.
module uram_row_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          i_core_req,
  input  logic [NUM_CORES-1:0]          i_core_locked,
  output logic [NUM_CORES-1:0]          o_core_grant,
  input  logic [NUM_CORES-1:0]          i_core_uram_en,
  input  logic [NUM_CORES*12-1:0]       i_core_uram_addr,
  input  logic [NUM_CORES*32-1:0]       i_core_uram_wr_data,
  input  logic [NUM_CORES-1:0]          i_core_uram_wr_en,
  output logic                          o_uram_en,
  output logic [11:0]                   o_uram_addr,
  output logic [31:0]                   o_uram_wr_data,
  output logic                          o_uram_wr_en,
  output logic [$clog2(NUM_CORES)-1:0]  o_grant_id,
  output logic                          o_busy,
  output logic                          o_timeout
);
  localparam int IdW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [IdW-1:0]       rr_q, rr_d;
  logic [IdW-1:0]       rr_next;
  logic [NUM_CORES-1:0] eligible;
  logic                 hold;
  logic                 timeout_hit;
  logic                 pick_found;
  logic [IdW-1:0]       pick_id;

  assign hold    = i_core_req[id_q] | i_core_locked[id_q];
  assign rr_next = (id_q == IdW'(NUM_CORES - 1)) ? '0 : id_q + IdW'(1);

  // First eligible requester at or after rr_q, wrapping; idx < 2*NUM_CORES so one subtract suffices.
  always_comb begin
    logic [IdW:0] idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, rr_q} + (IdW+1)'(i);
      if (idx >= (IdW+1)'(NUM_CORES)) idx = idx - (IdW+1)'(NUM_CORES);
      if (!pick_found && eligible[idx[IdW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = idx[IdW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = NUM_CORES'(1) << pick_id;
          id_d    = pick_id;
        end
      end
      GRANT: begin
        if (!hold || timeout_hit) begin
          state_d = RELEASE;
          grant_d = '0;
          rr_d    = rr_next;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Each core's fields are gated by its own grant bit, so idle cores cannot disturb the port.
  logic [NUM_CORES-1:0]       m_en, m_wr;
  logic [NUM_CORES-1:0][11:0] m_addr;
  logic [NUM_CORES-1:0][31:0] m_data;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_mask
    assign m_en[gi]   = i_core_uram_en[gi] & grant_q[gi];
    assign m_wr[gi]   = i_core_uram_wr_en[gi] & grant_q[gi];
    assign m_addr[gi] = i_core_uram_addr[12*gi +: 12] & {12{grant_q[gi]}};
    assign m_data[gi] = i_core_uram_wr_data[32*gi +: 32] & {32{grant_q[gi]}};
  end

  always_comb begin
    o_core_grant   = grant_q;
    o_grant_id     = id_q;
    o_busy         = (state_q == GRANT);
    o_uram_en      = |m_en;
    o_uram_wr_en   = |m_wr;
    o_uram_addr    = '0;
    o_uram_wr_data = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      o_uram_addr    = o_uram_addr | m_addr[k];
      o_uram_wr_data = o_uram_wr_data | m_data[k];
    end
  end

`ifdef URAM_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0]      wd_cnt_q, wd_cnt_d;
  logic [NUM_CORES-1:0] blocked_q, blocked_d;
  logic                 timeout_q, timeout_d;

  assign timeout_hit = (state_q == GRANT) && (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign eligible    = i_core_req & ~blocked_q;
  assign o_timeout   = timeout_q;

  // A revoked core stays blocked until it drops both request and lock for a cycle.
  always_comb begin
    wd_cnt_d  = (state_q == GRANT) ? wd_cnt_q + CntW'(1) : '0;
    blocked_d = blocked_q & (i_core_req | i_core_locked);
    timeout_d = timeout_q;
    if (timeout_hit && hold) begin
      blocked_d[id_q] = 1'b1;
      timeout_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      blocked_q <= blocked_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign eligible    = i_core_req;
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uram_row_arbiter.sv
// Directed bench for uram_row_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_uram_row_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, lock, en, wr;
  logic [47:0]  addr;
  logic [127:0] data;
  logic [3:0]   grant;
  logic         u_en, u_wr, busy, tmo;
  logic [11:0]  u_addr;
  logic [31:0]  u_data;
  logic [1:0]   gid;

  always #5 clk = ~clk;

  uram_row_arbiter #(.NUM_CORES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_core_req          (req),
    .i_core_locked       (lock),
    .o_core_grant        (grant),
    .i_core_uram_en      (en),
    .i_core_uram_addr    (addr),
    .i_core_uram_wr_data (data),
    .i_core_uram_wr_en   (wr),
    .o_uram_en           (u_en),
    .o_uram_addr         (u_addr),
    .o_uram_wr_data      (u_data),
    .o_uram_wr_en        (u_wr),
    .o_grant_id          (gid),
    .o_busy              (busy),
    .o_timeout           (tmo)
  );

  typedef struct {
    logic [3:0]  req, lock, en, wr;
    logic [3:0]  e_grant;
    logic [1:0]  e_id;
    logic        e_busy, e_en, e_wr;
    logic [11:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [14];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(logic [3:0] r, logic [3:0] l, logic [3:0] e, logic [3:0] w,
                              logic [3:0] g, logic [1:0] id, logic b, logic ue,
                              logic [11:0] ua, logic [31:0] ud, logic uw);
    vec_t v;
    v.req = r; v.lock = l; v.en = e; v.wr = w;
    v.e_grant = g; v.e_id = id; v.e_busy = b; v.e_en = ue;
    v.e_addr = ua; v.e_data = ud; v.e_wr = uw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0; lock = '0; en = '0; wr = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_port(input string tag, input logic e_en, input logic [11:0] e_addr,
                          input logic [31:0] e_data, input logic e_wr);
    chk({tag, "_uram_en"},   32'(u_en),   32'(e_en));
    chk({tag, "_uram_addr"}, 32'(u_addr), 32'(e_addr));
    chk({tag, "_uram_data"}, u_data,      e_data);
    chk({tag, "_uram_wr"},   32'(u_wr),   32'(e_wr));
  endtask

  initial begin
    // Core 3 carries the recognisable pattern; core 0 drives garbage.
    addr = {12'h0AB, 12'h222, 12'h111, 12'hFFF};
    data = {32'hDEADBEEF, 32'h22222222, 32'h11111111, 32'h12345678};

    //          req      lock     en       wr       grant    id    busy  en    addr     data           wr
    vecs[0]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 12'h111, 32'h11111111, 1'b0);
    vecs[1]  = mk(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 12'h111, 32'h11111111, 1'b0);
    vecs[2]  = mk(4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 12'h111, 32'h11111111, 1'b1);
    vecs[3]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);
    vecs[4]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);
    vecs[5]  = mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 12'h0AB, 32'hDEADBEEF, 1'b0);
    vecs[6]  = mk(4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1, 12'h0AB, 32'hDEADBEEF, 1'b1);
    vecs[7]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);
    vecs[8]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);
    vecs[9]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 12'hFFF, 32'h12345678, 1'b1);
    vecs[10] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);
    vecs[11] = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);
    vecs[12] = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);
    vecs[13] = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 12'h000, 32'h00000000, 1'b0);

    reset = 1'b1;
    req = '0; lock = '0; en = '0; wr = '0;
    step();
    step();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_id",    32'(gid),   32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_tmo",   32'(tmo),   32'd0);
    chk_port("reset", 1'b0, 12'h000, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 14; v++) begin
      req = vecs[v].req; lock = vecs[v].lock; en = vecs[v].en; wr = vecs[v].wr;
      step();
      $display("vec %0d: req=%b lock=%b -> grant=%b id=%0d busy=%b uram_en=%b addr=%h data=%h wr=%b",
               v, req, lock, grant, gid, busy, u_en, u_addr, u_data, u_wr);
      chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].e_grant));
      chk($sformatf("vec%0d_id", v),    32'(gid),   32'(vecs[v].e_id));
      chk($sformatf("vec%0d_busy", v),  32'(busy),  32'(vecs[v].e_busy));
      chk($sformatf("vec%0d_tmo", v),   32'(tmo),   32'd0);
      chk_port($sformatf("vec%0d", v), vecs[v].e_en, vecs[v].e_addr, vecs[v].e_data, vecs[v].e_wr);
    end

    // Every core wants access and gives it up after one granted cycle.
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      logic [3:0] exp_g;
      step();
      exp_g = (k % 3 == 0) ? 4'(1 << ((k / 3) % 4)) : 4'b0000;
      $display("rr cycle %0d: grant=%b id=%0d", k, grant, gid);
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(exp_g));
      if (k % 3 == 0) chk($sformatf("rr%0d_id", k), 32'(gid), 32'((k / 3) % 4));
      req = ~grant;
    end

    // Lock extends core 2's ownership while core 0 waits.
    apply_reset();
    req = 4'b0100;
    step();
    chk("lock_first_grant", 32'(grant), 32'b0100);
    chk("lock_first_id",    32'(gid),   32'd2);
    req = 4'b0001; lock = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      $display("lock cycle %0d: grant=%b", k, grant);
      chk($sformatf("lock_hold%0d", k), 32'(grant), 32'b0100);
    end
    lock = 4'b0000;
    step(); chk("lock_release", 32'(grant), 32'b0000);
    step(); chk("lock_idle",    32'(grant), 32'b0000);
    step(); chk("lock_next_grant", 32'(grant), 32'b0001);
    chk("lock_next_id", 32'(gid), 32'd0);
    req = 4'b0000;
    step();
    step();

    // Asynchronous reset while core 3 owns the port.
    apply_reset();
    req = 4'b0010;
    step(); chk("ar_g1", 32'(grant), 32'b0010);
    req = 4'b0000;
    step();
    step();
    req = 4'b1000; en = 4'b1000; wr = 4'b1000;
    step();
    chk("ar_g3", 32'(grant), 32'b1000);
    chk_port("ar_live", 1'b1, 12'h0AB, 32'hDEADBEEF, 1'b1);
    #2 reset = 1'b1;
    #1;
    $display("async reset: grant=%b busy=%b uram_en=%b", grant, busy, u_en);
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_busy",  32'(busy),  32'd0);
    chk("ar_id",    32'(gid),   32'd0);
    chk_port("ar_zero", 1'b0, 12'h000, 32'h0, 1'b0);
    #1 reset = 1'b0;
    req = 4'b0110; en = 4'b0000; wr = 4'b0000;
    step();
    chk("ar_after_grant", 32'(grant), 32'b0010);
    chk("ar_after_id",    32'(gid),   32'd1);
    req = 4'b0000;
    step();
    step();

`ifdef URAM_ARB_TIMEOUT_EN
    // Core 0 never lets go; the watchdog must hand the port to core 1.
    apply_reset();
    lock = 4'b0001; req = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("wd_hold%0d", k), 32'(grant), 32'b0001);
      chk($sformatf("wd_tmo%0d", k),  32'(tmo),   32'd0);
    end
    step(); chk("wd_revoke", 32'(grant), 32'b0000);
    chk("wd_tmo_set", 32'(tmo), 32'd1);
    step(); chk("wd_idle", 32'(grant), 32'b0000);
    step(); chk("wd_core1", 32'(grant), 32'b0010);
    chk("wd_core1_id", 32'(gid), 32'd1);
    req = 4'b0001;
    step();
    step();
    step(); chk("wd_blocked_a", 32'(grant), 32'b0000);
    step(); chk("wd_blocked_b", 32'(grant), 32'b0000);
    req = 4'b0000; lock = 4'b0000;
    step();
    req = 4'b0001;
    step(); chk("wd_regrant", 32'(grant), 32'b0001);
    chk("wd_tmo_sticky", 32'(tmo), 32'd1);
    $display("watchdog: grant=%b timeout=%b", grant, tmo);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
